// File: rtl/btn_pulse_pkg.sv
// Shared types and timing defaults for the push-button conditioning chain.
// Default counts assume a 25 kHz system clock.
package btn_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 125;    // 5 ms
  localparam int DEF_HOLD_CYCLES     = 12500;  // 500 ms
  localparam int DEF_REPEAT_CYCLES   = 2500;   // 100 ms

  // $clog2 returns 0 for 1; every counter needs at least one bit
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-FF synchroniser, integrating debounce, and a press/hold/repeat
// FSM that emits an unregistered one-cycle request pulse.
module btn_debounce_chan
  import btn_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse_raw
);

  localparam int DW = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam int HW = clog2_min1(HOLD_CYCLES + 1);
  localparam int RW = clog2_min1(REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HC_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HC_SAT  = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] RC_LAST = RW'(REPEAT_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [DW-1:0] dc;
  logic [HW-1:0] hc;
  logic [RW-1:0] rc;
  state_t        state;
  state_t        state_n;
  logic          hold_done;
  logic          rpt_done;

  // Stage p0/p1: metastability guard; nothing else looks at raw
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: level follows the synchronised input only after an unbroken disagreement run
  always_ff @(posedge clk) begin
    if (!rst) begin
      dc    <= '0;
      level <= 1'b0;
    end else if (sync_p1 == level) begin
      dc <= '0;
    end else if (dc == DC_LAST) begin
      level <= sync_p1;
      dc    <= '0;
    end else begin
      dc <= dc + DW'(1);
    end
  end

  assign hold_done = (state == HOLD) && (hc == HC_LAST) && (REPEAT_EN != 0);
  assign rpt_done  = (state == RPT) && (rc == RC_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (!level) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_n = HOLD;
        HOLD:    state_n = hold_done ? RPT : HOLD;
        RPT:     state_n = RPT;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    pulse_raw = 1'b0;
    if (level) begin
      unique case (state)
        IDLE:    pulse_raw = 1'b1;
        HOLD:    pulse_raw = hold_done;
        RPT:     pulse_raw = rpt_done;
        default: pulse_raw = 1'b0;
      endcase
    end
  end

  // hc parks at HOLD_CYCLES when repeat is off, so it can never wrap back onto HC_LAST
  always_ff @(posedge clk) begin
    if (!rst) begin
      hc <= '0;
      rc <= '0;
    end else begin
      if ((state != HOLD) || !level) begin
        hc <= '0;
      end else if (hc != HC_SAT) begin
        hc <= hc + HW'(1);
      end

      if ((state != RPT) || !level || rpt_done) begin
        rc <= '0;
      end else begin
        rc <= rc + RW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_pulse_conditioner.sv
// Turns raw push-button levels into clean single-cycle inc/dec request pulses,
// dropping any cycle in which more than one channel would fire.
module btn_pulse_conditioner
  import btn_pulse_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int REPEAT_EN       = 1,
  parameter int EXCLUSIVE       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  logic [NUM_BTN-1:0] pulse_raw;
  logic [NUM_BTN-1:0] pulse_p0;

  function automatic logic multi_hot(input logic [NUM_BTN-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_BTN; i++) begin
      n += int'(v[i]);
    end
    return (n > 1);
  endfunction

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .raw       (btn_raw[g]),
      .level     (btn_level[g]),
      .pulse_raw (pulse_raw[g])
    );
  end

  // Conflicting requests cancel; the channel FSMs keep running so later repeats still fire
  always_comb begin
    pulse_p0 = pulse_raw;
    if ((EXCLUSIVE != 0) && multi_hot(pulse_raw)) begin
      pulse_p0 = '0;
    end
  end

  // Stage p1: registered output toward the counter block
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_pulse <= '0;
    end else begin
      btn_pulse <= pulse_p0;
    end
  end

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Directed bench for btn_pulse_conditioner with short timing (debounce 4, hold 20, repeat 8).
// Three instances share stimulus: default, EXCLUSIVE=0, and REPEAT_EN=0.
module tb_btn_pulse_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] lvl_a, pls_a;
  logic [1:0] lvl_x, pls_x;
  logic [1:0] lvl_n, pls_n;
  int         total;
  int         bad;
  int         npls;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  btn_pulse_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8),
    .REPEAT_EN(1), .EXCLUSIVE(1)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(lvl_a), .btn_pulse(pls_a)
  );

  btn_pulse_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8),
    .REPEAT_EN(1), .EXCLUSIVE(0)
  ) dut_x (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(lvl_x), .btn_pulse(pls_x)
  );

  btn_pulse_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8),
    .REPEAT_EN(0), .EXCLUSIVE(1)
  ) dut_n (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(lvl_n), .btn_pulse(pls_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    npls    = 0;
    rst     = 1'b0;
    btn_raw = 2'b00;

    // reset state
    repeat (3) step();
    chk("rst_level_a", 32'(lvl_a), 32'h0);
    chk("rst_pulse_a", 32'(pls_a), 32'h0);
    chk("rst_pulse_x", 32'(pls_x), 32'h0);
    chk("rst_pulse_n", 32'(pls_n), 32'h0);
    rst = 1'b1;
    repeat (3) step();

    // 1: clean press on ch0, 10 cycles
    btn_raw = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("t1_pulse_%0d", i), 32'(pls_a), (i == 7) ? 32'h1 : 32'h0);
      chk($sformatf("t1_level_%0d", i), 32'(lvl_a), (i >= 6) ? 32'h1 : 32'h0);
    end
    btn_raw = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("t1_rel_pulse_%0d", i), 32'(pls_a), 32'h0);
    end
    chk("t1_rel_level", 32'(lvl_a), 32'h0);

    // 2: bounce every cycle, then steady high
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0) ? 2'b01 : 2'b00;
      step();
      chk($sformatf("t2_bounce_pulse_%0d", i), 32'(pls_a), 32'h0);
    end
    btn_raw = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("t2_pulse_%0d", i), 32'(pls_a), (i == 7) ? 32'h1 : 32'h0);
    end
    btn_raw = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("t2_rel_pulse_%0d", i), 32'(pls_a), 32'h0);
    end

    // 3: hold ch1 for 60 cycles with auto-repeat
    btn_raw = 2'b10;
    for (int i = 1; i <= 60; i++) begin
      step();
      chk($sformatf("t3_pulse_%0d", i), 32'(pls_a),
          (i inside {7, 27, 35, 43, 51, 59}) ? 32'h2 : 32'h0);
      chk($sformatf("t3_norpt_pulse_%0d", i), 32'(pls_n), (i == 7) ? 32'h2 : 32'h0);
    end
    chk("t3_level_held", 32'(lvl_a), 32'h2);
    btn_raw = 2'b00;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("t3_rel_pulse_%0d", i), 32'(pls_a), 32'h0);
    end
    chk("t3_rel_level", 32'(lvl_a), 32'h0);

    // 4: simultaneous presses
    btn_raw = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("t4_excl_pulse_%0d", i), 32'(pls_a), 32'h0);
      chk($sformatf("t4_nonex_pulse_%0d", i), 32'(pls_x), (i == 7) ? 32'h3 : 32'h0);
      if (i >= 6) chk($sformatf("t4_level_%0d", i), 32'(lvl_a), 32'h3);
    end
    btn_raw = 2'b00;
    repeat (10) step();
    chk("t4_rel_level", 32'(lvl_a), 32'h0);

    // 5: reset while ch0 repeats, release reset with button still held
    btn_raw = 2'b01;
    repeat (30) step();
    rst = 1'b0;
    step();
    chk("t5_rst_level", 32'(lvl_a), 32'h0);
    chk("t5_rst_pulse", 32'(pls_a), 32'h0);
    step();
    rst = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      step();
      chk($sformatf("t5_pulse_%0d", i), 32'(pls_a),
          (i inside {7, 27, 35}) ? 32'h1 : 32'h0);
    end
    btn_raw = 2'b00;
    repeat (10) step();

    // 6: no auto-repeat: one pulse per press
    btn_raw = 2'b01;
    for (int i = 1; i <= 100; i++) begin
      step();
      npls += int'(pls_n[0]);
      chk($sformatf("t6_p1_pulse_%0d", i), 32'(pls_n), (i == 7) ? 32'h1 : 32'h0);
    end
    btn_raw = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      step();
      npls += int'(pls_n[0]);
    end
    btn_raw = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      step();
      npls += int'(pls_n[0]);
      chk($sformatf("t6_p2_pulse_%0d", i), 32'(pls_n), (i == 7) ? 32'h1 : 32'h0);
    end
    chk("t6_pulse_count", 32'(npls), 32'd2);
    btn_raw = 2'b00;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
